// File: rtl/legv8_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// legv8_ctrl_pkg
// Shared definitions for the LEGv8 multi-cycle control unit:
//   - OPCODE_* casez patterns for instr[31:21] ('?' bits are don't-care)
//   - ALUOP_* / SIGNOP_* control encodings
//   - FSM state, instruction class and trap-cause encodings
//   - is_mem_class() helper
// No ports (package).
// -----------------------------------------------------------------------------
package legv8_ctrl_pkg;

  // Opcode patterns, listed in decode priority order
  localparam logic [10:0] OPCODE_ANDREG = 11'b10001010000;
  localparam logic [10:0] OPCODE_ORRREG = 11'b10101010000;
  localparam logic [10:0] OPCODE_ADDREG = 11'b10001011000;
  localparam logic [10:0] OPCODE_SUBREG = 11'b11001011000;
  localparam logic [10:0] OPCODE_ADDIMM = 11'b1001000100?;
  localparam logic [10:0] OPCODE_SUBIMM = 11'b1101000100?;
  localparam logic [10:0] OPCODE_LDUR   = 11'b11111000010;
  localparam logic [10:0] OPCODE_STUR   = 11'b11111000000;
  localparam logic [10:0] OPCODE_B      = 11'b000101?????;
  localparam logic [10:0] OPCODE_CBZ    = 11'b10110100???;
  localparam logic [10:0] OPCODE_MOVZ   = 11'b110100101??;

  // ALU operation select
  localparam logic [3:0] ALUOP_AND  = 4'b0000;
  localparam logic [3:0] ALUOP_ORR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD  = 4'b0010;
  localparam logic [3:0] ALUOP_MOVZ = 4'b0101;
  localparam logic [3:0] ALUOP_SUB  = 4'b0110;
  localparam logic [3:0] ALUOP_CBZ  = 4'b0111;

  // Immediate extend mode
  localparam logic [2:0] SIGNOP_I    = 3'b000;
  localparam logic [2:0] SIGNOP_D    = 3'b001;
  localparam logic [2:0] SIGNOP_B    = 3'b010;
  localparam logic [2:0] SIGNOP_CBZ  = 3'b011;
  localparam logic [2:0] SIGNOP_MOVZ = 3'b100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE = 4'd0,
    CL_AND  = 4'd1,
    CL_ORR  = 4'd2,
    CL_ADD  = 4'd3,
    CL_SUB  = 4'd4,
    CL_ADDI = 4'd5,
    CL_SUBI = 4'd6,
    CL_LDUR = 4'd7,
    CL_STUR = 4'd8,
    CL_B    = 4'd9,
    CL_CBZ  = 4'd10,
    CL_MOVZ = 4'd11
  } instr_class_e;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_IMEM    = 2'b10,
    TC_DMEM    = 2'b11
  } trap_cause_e;

  function automatic logic is_mem_class(instr_class_e c);
    return (c == CL_LDUR) || (c == CL_STUR);
  endfunction

endpackage

// File: rtl/legv8_op_decode.sv
// -----------------------------------------------------------------------------
// legv8_op_decode
// Combinational opcode classifier. Maps instr[31:21] to an instruction class
// plus the static datapath controls used in EXEC/MEM/BRANCH. Don't-care
// controls of the textbook decode are driven 0.
// Ports:
//   opcode   in   OPCODE_W  opcode field
//   cls      out  class     instruction class (CL_NONE when illegal)
//   illegal  out  1         no pattern matched
//   reg2loc  out  1         second register read port selects Rt
//   alusrc   out  1         ALU B operand from immediate
//   aluop    out  ALUOP_W   ALU operation
//   signop   out  SIGNOP_W  immediate extend mode
// -----------------------------------------------------------------------------
module legv8_op_decode
  import legv8_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int ALUOP_W  = 4,
  parameter int SIGNOP_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_e        cls,
  output logic                illegal,
  output logic                reg2loc,
  output logic                alusrc,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [SIGNOP_W-1:0] signop
);

  logic [10:0] op;
  assign op = 11'(opcode);

  always_comb begin
    cls     = CL_NONE;
    illegal = 1'b0;
    reg2loc = 1'b0;
    alusrc  = 1'b0;
    aluop   = '0;
    signop  = '0;
    casez (op)
      OPCODE_ANDREG: begin
        cls   = CL_AND;
        aluop = ALUOP_W'(ALUOP_AND);
      end
      OPCODE_ORRREG: begin
        cls   = CL_ORR;
        aluop = ALUOP_W'(ALUOP_ORR);
      end
      OPCODE_ADDREG: begin
        cls   = CL_ADD;
        aluop = ALUOP_W'(ALUOP_ADD);
      end
      OPCODE_SUBREG: begin
        cls   = CL_SUB;
        aluop = ALUOP_W'(ALUOP_SUB);
      end
      OPCODE_ADDIMM: begin
        cls    = CL_ADDI;
        alusrc = 1'b1;
        aluop  = ALUOP_W'(ALUOP_ADD);
        signop = SIGNOP_W'(SIGNOP_I);
      end
      OPCODE_SUBIMM: begin
        cls    = CL_SUBI;
        alusrc = 1'b1;
        aluop  = ALUOP_W'(ALUOP_SUB);
        signop = SIGNOP_W'(SIGNOP_I);
      end
      OPCODE_LDUR: begin
        cls    = CL_LDUR;
        alusrc = 1'b1;
        aluop  = ALUOP_W'(ALUOP_ADD);
        signop = SIGNOP_W'(SIGNOP_D);
      end
      OPCODE_STUR: begin
        cls     = CL_STUR;
        reg2loc = 1'b1;
        alusrc  = 1'b1;
        aluop   = ALUOP_W'(ALUOP_ADD);
        signop  = SIGNOP_W'(SIGNOP_D);
      end
      OPCODE_B: begin
        cls    = CL_B;
        signop = SIGNOP_W'(SIGNOP_B);
      end
      OPCODE_CBZ: begin
        cls     = CL_CBZ;
        reg2loc = 1'b1;
        aluop   = ALUOP_W'(ALUOP_CBZ);
        signop  = SIGNOP_W'(SIGNOP_CBZ);
      end
      OPCODE_MOVZ: begin
        cls    = CL_MOVZ;
        alusrc = 1'b1;
        aluop  = ALUOP_W'(ALUOP_MOVZ);
        signop = SIGNOP_W'(SIGNOP_MOVZ);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle LEGv8 control FSM. Sequences the shared datapath over
// FETCH/DECODE/EXEC/MEM/WB/BRANCH, stalls on memory ready handshakes and traps
// on illegal opcodes or memory accesses that stay not-ready too long.
//
// state  | meaning
// FETCH  | imem_req high, wait for imem_ready, load IR
// DECODE | classify opcode, latch class and static controls
// EXEC   | ALU controls for the latched class
// MEM    | memread/memwrite held until dmem_ready
// WB     | register write, PC+4, retire
// BRANCH | PC update (taken for B, or CBZ with latched zero), retire
// TRAP   | absorbing until Reset, trap/trap_cause reported
//
// Ports:
//   CLK, Reset (sync, active high)
//   opcode, zero, imem_ready, dmem_ready      inputs
//   imem_req, ir_write, pc_write, pcsrc       fetch / PC controls
//   reg2loc, alusrc, mem2reg, regwrite,
//   memread, memwrite, aluop, signop          datapath controls
//   retire, trap, trap_cause                  status
// -----------------------------------------------------------------------------
module multicycle_control
  import legv8_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 11,
  parameter int ALUOP_W     = 4,
  parameter int SIGNOP_W    = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pcsrc,
  output logic                reg2loc,
  output logic                alusrc,
  output logic                mem2reg,
  output logic                regwrite,
  output logic                memread,
  output logic                memwrite,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [SIGNOP_W-1:0] signop,
  output logic                retire,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  trap_cause_e   cause_q, cause_d;
  logic [CNT_W-1:0] wait_cnt;
  logic          waiting;
  logic          wait_last;

  instr_class_e        dec_cls;
  logic                dec_illegal;
  logic                dec_reg2loc;
  logic                dec_alusrc;
  logic [ALUOP_W-1:0]  dec_aluop;
  logic [SIGNOP_W-1:0] dec_signop;

  instr_class_e        cls_q;
  logic                reg2loc_q;
  logic                alusrc_q;
  logic [ALUOP_W-1:0]  aluop_q;
  logic [SIGNOP_W-1:0] signop_q;
  logic                zero_q;

  legv8_op_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W),
    .SIGNOP_W (SIGNOP_W)
  ) u_decode (
    .opcode  (opcode),
    .cls     (dec_cls),
    .illegal (dec_illegal),
    .reg2loc (dec_reg2loc),
    .alusrc  (dec_alusrc),
    .aluop   (dec_aluop),
    .signop  (dec_signop)
  );

  // A wait cycle is one spent in FETCH/MEM with the matching ready low
  assign waiting   = ((state_q == S_FETCH) && !imem_ready) ||
                     ((state_q == S_MEM)   && !dmem_ready);
  assign wait_last = (wait_cnt == WAIT_LAST);

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; ready always wins over the timeout on the last wait cycle
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_last) begin
          state_d = S_TRAP;
          cause_d = TC_IMEM;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_TRAP;
          cause_d = TC_ILLEGAL;
        end else if (dec_cls == CL_B) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mem_class(cls_q))  state_d = S_MEM;
        else if (cls_q == CL_CBZ) state_d = S_BRANCH;
        else                      state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (cls_q == CL_LDUR) ? S_WB : S_FETCH;
        end else if (wait_last) begin
          state_d = S_TRAP;
          cause_d = TC_DMEM;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Wait counter saturates at WAIT_LAST; the FSM leaves the state there anyway
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if (waiting && !wait_last) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Class / static-control / zero / trap-cause latches
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cls_q     <= CL_NONE;
      reg2loc_q <= 1'b0;
      alusrc_q  <= 1'b0;
      aluop_q   <= '0;
      signop_q  <= '0;
      zero_q    <= 1'b0;
      cause_q   <= TC_NONE;
    end else begin
      cause_q <= cause_d;
      if (state_q == S_DECODE) begin
        cls_q     <= dec_cls;
        reg2loc_q <= dec_reg2loc;
        alusrc_q  <= dec_alusrc;
        aluop_q   <= dec_aluop;
        signop_q  <= dec_signop;
      end
      if ((state_q == S_EXEC) && (cls_q == CL_CBZ)) begin
        zero_q <= zero;
      end
    end
  end

  // Output decode. Reset forces everything low in the same cycle so a pending
  // memory write is dropped rather than completed.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pcsrc      = 1'b0;
    reg2loc    = 1'b0;
    alusrc     = 1'b0;
    mem2reg    = 1'b0;
    regwrite   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    aluop      = '0;
    signop     = '0;
    retire     = 1'b0;
    trap       = 1'b0;
    trap_cause = TC_NONE;
    if (!Reset) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        S_EXEC: begin
          reg2loc = reg2loc_q;
          alusrc  = alusrc_q;
          aluop   = aluop_q;
          signop  = signop_q;
        end
        S_MEM: begin
          // ALU controls held so the address stays valid during the stall
          reg2loc  = reg2loc_q;
          alusrc   = alusrc_q;
          aluop    = aluop_q;
          signop   = signop_q;
          memread  = (cls_q == CL_LDUR);
          memwrite = (cls_q == CL_STUR);
          if (dmem_ready && (cls_q == CL_STUR)) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        end
        S_WB: begin
          regwrite = 1'b1;
          mem2reg  = (cls_q == CL_LDUR);
          pc_write = 1'b1;
          retire   = 1'b1;
        end
        S_BRANCH: begin
          pc_write = 1'b1;
          retire   = 1'b1;
          signop   = signop_q;
          pcsrc    = (cls_q == CL_B) || ((cls_q == CL_CBZ) && zero_q);
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control (MEM_TIMEOUT = 8). Expected
// per-cycle outputs come from an instruction-level model: each instruction is
// expanded into its phases (fetch waits, decode, exec, memory waits,
// writeback/branch) using the published latency and control rules.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int MT = 8;

  logic        CLK;
  logic        Reset;
  logic [10:0] opcode;
  logic        zero, imem_ready, dmem_ready;
  logic        imem_req, ir_write, pc_write, pcsrc, reg2loc, alusrc;
  logic        mem2reg, regwrite, memread, memwrite, retire, trap;
  logic [3:0]  aluop;
  logic [2:0]  signop;
  logic [1:0]  trap_cause;

  multicycle_control #(
    .OPCODE_W(11), .ALUOP_W(4), .SIGNOP_W(3), .MEM_TIMEOUT(MT)
  ) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pcsrc(pcsrc),
    .reg2loc(reg2loc), .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite),
    .memread(memread), .memwrite(memwrite), .aluop(aluop), .signop(signop),
    .retire(retire), .trap(trap), .trap_cause(trap_cause)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic imem_req, ir_write, pc_write, pcsrc, reg2loc, alusrc;
    logic mem2reg, regwrite, memread, memwrite;
    logic [3:0] aluop;
    logic [2:0] signop;
    logic retire, trap;
    logic [1:0] trap_cause;
  } out_t;

  out_t act;
  assign act = {imem_req, ir_write, pc_write, pcsrc, reg2loc, alusrc,
                mem2reg, regwrite, memread, memwrite, aluop, signop,
                retire, trap, trap_cause};

  // kind: 0 ALU->WB, 1 load, 2 store, 3 B, 4 CBZ
  typedef struct {
    logic [10:0] mask;
    logic [10:0] val;
    logic        r2l;
    logic        asrc;
    logic [3:0]  aop;
    logic [2:0]  sop;
    int          kind;
  } op_info_t;

  typedef struct {
    logic [10:0] opc;
    int          iw;
    int          dw;
    logic        z;
    int          lat;
  } vec_t;

  op_info_t op_tab [11];
  vec_t     vecs   [16];
  int errors = 0;
  int checks = 0;
  int cyc_idx;
  int retire_at;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] rnd_op();
    return 11'($urandom);
  endfunction

  function automatic int classify(input logic [10:0] opc);
    for (int i = 0; i < 11; i++)
      if ((opc & op_tab[i].mask) == op_tab[i].val) return i;
    return -1;
  endfunction

  function automatic out_t exp_alu(input int k);
    out_t e;
    e = '0;
    e.reg2loc = op_tab[k].r2l;
    e.alusrc  = op_tab[k].asrc;
    e.aluop   = op_tab[k].aop;
    e.signop  = op_tab[k].sop;
    return e;
  endfunction

  task automatic step(input logic ir, input logic dr, input logic z,
                      input logic [10:0] opc, input logic rst,
                      input out_t exp, input string nm);
    @(negedge CLK);
    imem_ready = ir;
    dmem_ready = dr;
    zero       = z;
    opcode     = opc;
    Reset      = rst;
    #1;
    cyc_idx++;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc_idx, act, exp);
    end
    if (act.retire === 1'b1 && retire_at < 0) retire_at = cyc_idx;
  endtask

  task automatic do_reset(input int n);
    out_t e;
    e = '0;
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, rb(), rnd_op(), 1'b1, e, "reset");
  endtask

  task automatic check_trap(input logic [1:0] cause, input int n, input string nm);
    out_t e;
    e = '0;
    e.trap = 1'b1;
    e.trap_cause = cause;
    for (int i = 0; i < n; i++) step(1'(i & 1), rb(), rb(), rnd_op(), 1'b0, e, nm);
  endtask

  // One instruction from its first FETCH cycle. iw/dw >= MT model a timeout:
  // the task stops after the last wait cycle and the caller checks the trap.
  task automatic run_instr(input logic [10:0] opc, input int iw, input int dw,
                           input logic z, input string nm);
    out_t e;
    int   k;
    int   kind;
    cyc_idx   = 0;
    retire_at = -1;
    k = classify(opc);
    e = '0;
    e.imem_req = 1'b1;
    for (int i = 0; i < ((iw >= MT) ? MT : iw); i++)
      step(1'b0, rb(), rb(), rnd_op(), 1'b0, e, nm);
    if (iw >= MT) return;
    e.ir_write = 1'b1;
    step(1'b1, rb(), rb(), rnd_op(), 1'b0, e, nm);
    e = '0;
    step(rb(), rb(), rb(), opc, 1'b0, e, nm);
    if (k < 0) return;
    kind = op_tab[k].kind;
    if (kind == 3) begin
      e = '0;
      e.pc_write = 1'b1;
      e.retire   = 1'b1;
      e.pcsrc    = 1'b1;
      e.signop   = op_tab[k].sop;
      step(rb(), rb(), rb(), rnd_op(), 1'b0, e, nm);
      return;
    end
    e = exp_alu(k);
    step(rb(), rb(), z, rnd_op(), 1'b0, e, nm);
    if (kind == 1 || kind == 2) begin
      e.memread  = (kind == 1);
      e.memwrite = (kind == 2);
      for (int i = 0; i < ((dw >= MT) ? MT : dw); i++)
        step(rb(), 1'b0, rb(), rnd_op(), 1'b0, e, nm);
      if (dw >= MT) return;
      if (kind == 2) begin
        e.pc_write = 1'b1;
        e.retire   = 1'b1;
      end
      step(rb(), 1'b1, rb(), rnd_op(), 1'b0, e, nm);
      if (kind == 2) return;
    end
    e = '0;
    if (kind == 4) begin
      e.pc_write = 1'b1;
      e.retire   = 1'b1;
      e.signop   = op_tab[k].sop;
      e.pcsrc    = z;
    end else begin
      e.regwrite = 1'b1;
      e.mem2reg  = (kind == 1);
      e.pc_write = 1'b1;
      e.retire   = 1'b1;
    end
    step(rb(), rb(), rb(), rnd_op(), 1'b0, e, nm);
  endtask

  initial begin
    out_t e;
    int   k;
    logic [10:0] opc;

    //             mask            val             r2l   asrc  aluop    signop  kind
    op_tab[0]  = '{11'h7FF,        11'b10001010000, 1'b0, 1'b0, 4'b0000, 3'b000, 0}; // AND
    op_tab[1]  = '{11'h7FF,        11'b10101010000, 1'b0, 1'b0, 4'b0001, 3'b000, 0}; // ORR
    op_tab[2]  = '{11'h7FF,        11'b10001011000, 1'b0, 1'b0, 4'b0010, 3'b000, 0}; // ADD
    op_tab[3]  = '{11'h7FF,        11'b11001011000, 1'b0, 1'b0, 4'b0110, 3'b000, 0}; // SUB
    op_tab[4]  = '{11'b11111111110, 11'b10010001000, 1'b0, 1'b1, 4'b0010, 3'b000, 0}; // ADDI
    op_tab[5]  = '{11'b11111111110, 11'b11010001000, 1'b0, 1'b1, 4'b0110, 3'b000, 0}; // SUBI
    op_tab[6]  = '{11'h7FF,        11'b11111000010, 1'b0, 1'b1, 4'b0010, 3'b001, 1}; // LDUR
    op_tab[7]  = '{11'h7FF,        11'b11111000000, 1'b1, 1'b1, 4'b0010, 3'b001, 2}; // STUR
    op_tab[8]  = '{11'b11111100000, 11'b00010100000, 1'b0, 1'b0, 4'b0000, 3'b010, 3}; // B
    op_tab[9]  = '{11'b11111111000, 11'b10110100000, 1'b1, 1'b0, 4'b0111, 3'b011, 4}; // CBZ
    op_tab[10] = '{11'b11111111100, 11'b11010010100, 1'b0, 1'b1, 4'b0101, 3'b100, 0}; // MOVZ

    //           opcode          iw dw  z     latency
    vecs[0]  = '{11'b10001011000, 0, 0, 1'b0, 4};   // ADD
    vecs[1]  = '{11'b10001010000, 0, 0, 1'b0, 4};   // AND
    vecs[2]  = '{11'b10101010000, 2, 0, 1'b0, 6};   // ORR, 2 fetch waits
    vecs[3]  = '{11'b11001011000, 0, 0, 1'b0, 4};   // SUB
    vecs[4]  = '{11'b10010001001, 0, 0, 1'b0, 4};   // ADDI
    vecs[5]  = '{11'b11010001000, 0, 0, 1'b0, 4};   // SUBI
    vecs[6]  = '{11'b11010010110, 0, 0, 1'b0, 4};   // MOVZ
    vecs[7]  = '{11'b11111000010, 0, 3, 1'b0, 8};   // LDUR, 3 mem waits
    vecs[8]  = '{11'b11111000010, 0, 0, 1'b0, 5};   // LDUR
    vecs[9]  = '{11'b11111000000, 0, 0, 1'b0, 4};   // STUR
    vecs[10] = '{11'b11111000000, 0, 7, 1'b0, 11};  // STUR, ready on 8th wait cycle
    vecs[11] = '{11'b10110100101, 0, 0, 1'b1, 4};   // CBZ taken
    vecs[12] = '{11'b10110100101, 0, 0, 1'b0, 4};   // CBZ not taken
    vecs[13] = '{11'b00010111111, 0, 0, 1'b0, 3};   // B
    vecs[14] = '{11'b10001011000, 7, 0, 1'b0, 11};  // ADD, fetch ready on 8th wait
    vecs[15] = '{11'b11111000010, 7, 7, 1'b0, 19};  // LDUR, both late

    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    zero       = 1'b0;
    opcode     = '0;
    Reset      = 1'b1;
    cyc_idx    = 0;
    retire_at  = -1;

    do_reset(3);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      run_instr(vecs[i].opc, vecs[i].iw, vecs[i].dw, vecs[i].z, $sformatf("vec%0d", i));
      checks++;
      if (retire_at != vecs[i].lat) begin
        errors++;
        $display("FAIL vec%0d_latency got=%0d want=%0d", i, retire_at, vecs[i].lat);
      end
    end

    // Illegal opcode: trap absorbs, only Reset clears it
    run_instr(11'h000, 0, 0, 1'b0, "illegal");
    check_trap(2'b01, 6, "illegal_trap");
    do_reset(1);
    run_instr(11'b10001011000, 0, 0, 1'b0, "after_illegal");

    // STUR never ready: 8 memwrite cycles then dmem timeout
    run_instr(11'b11111000000, 0, MT, 1'b0, "dmem_timeout");
    check_trap(2'b11, 4, "dmem_trap");
    do_reset(1);

    // Instruction memory never ready
    run_instr(11'b10001011000, MT, 0, 1'b0, "imem_timeout");
    check_trap(2'b10, 4, "imem_trap");
    do_reset(2);

    // Reset during a stalled STUR: memwrite drops in the reset cycle itself
    k = 7;
    cyc_idx = 0;
    e = '0; e.imem_req = 1'b1; e.ir_write = 1'b1;
    step(1'b1, 1'b0, 1'b0, rnd_op(), 1'b0, e, "rst_mem_fetch");
    e = '0;
    step(1'b0, 1'b0, 1'b0, op_tab[k].val, 1'b0, e, "rst_mem_decode");
    e = exp_alu(k);
    step(1'b0, 1'b0, 1'b0, rnd_op(), 1'b0, e, "rst_mem_exec");
    e.memwrite = 1'b1;
    step(1'b0, 1'b0, 1'b0, rnd_op(), 1'b0, e, "rst_mem_wait");
    step(1'b0, 1'b0, 1'b0, rnd_op(), 1'b0, e, "rst_mem_wait");
    e = '0;
    step(1'b0, 1'b0, 1'b0, rnd_op(), 1'b1, e, "rst_mem_reset");
    e.imem_req = 1'b1;
    step(1'b0, 1'b0, 1'b0, rnd_op(), 1'b0, e, "rst_mem_refetch");
    run_instr(11'b11111000000, 0, 0, 1'b0, "after_rst_mem");

    // Randomized instruction stream against the model
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        opc = rnd_op();
      end else begin
        k   = int'($urandom_range(0, 10));
        opc = op_tab[k].val | (rnd_op() & ~op_tab[k].mask);
      end
      run_instr(opc,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0,
                int'($urandom_range(0, 7)),
                rb(), "random");
      if (classify(opc) < 0) begin
        check_trap(2'b01, 3, "random_illegal");
        do_reset(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
